// File: rtl/spi_frame_decoder.sv
// SPI mode-0 receive stage: assembles 16-bit frames and commits writes into five PWM control registers.
// Optional SPI_FRAME_ERR_EN adds frame_err / err_count outputs for discarded frames.
module spi_frame_decoder #(
    parameter int MAX_ADDR   = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_sync,
    input  logic       copi_sync,
    input  logic       ncs_sync,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
`ifdef SPI_FRAME_ERR_EN
    output logic       frame_err,
    output logic [7:0] err_count,
`endif
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);
    // Only five physical registers exist, so clamp the writable range to them.
    localparam logic [6:0] WR_LIMIT = (MAX_ADDR < 4) ? 7'(MAX_ADDR) : 7'd4;

    logic [1:0]  state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sclkPrev_q, ncsPrev_q;
    logic [7:0]  regs_q [0:4];

    logic        sclkRise, ncsFall, ncsRise;
    logic        isFull, wrEn;
    logic [6:0]  addr;

    assign sclkRise = !sclkPrev_q && sclk_sync;
    assign ncsFall  = ncsPrev_q && !ncs_sync;
    assign ncsRise  = !ncsPrev_q && ncs_sync;

    assign addr   = shreg_q[14:8];
    assign isFull = (cnt_q == CNT_FULL);
    assign wrEn   = (state_q == COMMIT) && isFull && shreg_q[15] && (addr <= WR_LIMIT);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ncsFall) begin
                    shreg_d = 16'h0000;
                    cnt_d   = 5'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ncsRise) begin
                    state_d = COMMIT;
                end else if (sclkRise && !ncs_sync) begin
                    shreg_d = {shreg_q[14:0], copi_sync};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= 16'h0000;
            cnt_q      <= 5'd0;
            sclkPrev_q <= 1'b0;
            ncsPrev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            sclkPrev_q <= sclk_sync;
            ncsPrev_q  <= ncs_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (wrEn && (addr == 7'(i))) begin
                    regs_q[i] <= shreg_q[7:0];
                end
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_FRAME_ERR_EN
    logic       errPulse;
    logic [7:0] errCount_q;

    // Well-formed read frames are legitimate traffic, not errors.
    assign errPulse = (state_q == COMMIT) && !wrEn && !(isFull && !shreg_q[15]);

    always_ff @(posedge clk) begin
        if (rst) begin
            errCount_q <= 8'h00;
        end else if (errPulse && (errCount_q != 8'hFF)) begin
            errCount_q <= errCount_q + 8'h01;
        end
    end

    assign frame_err = errPulse;
    assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Self-checking bench for spi_frame_decoder: a byte-level register model feeds a scoreboard queue
// compared against the five register outputs after each frame.
module tb_spi_frame_decoder;

    logic       clk;
    logic       rst;
    logic       sclk_sync;
    logic       copi_sync;
    logic       ncs_sync;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
    logic [7:0] err_count;
    int         errPulses;
    int         errModel;
`endif

    int compared;
    int mismatched;

    logic [7:0]  regModel [0:4];
    logic [39:0] expQ [$];

    spi_frame_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .sclk_sync       (sclk_sync),
        .copi_sync       (copi_sync),
        .ncs_sync        (ncs_sync),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
`ifdef SPI_FRAME_ERR_EN
        .frame_err       (frame_err),
        .err_count       (err_count),
`endif
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SPI_FRAME_ERR_EN
    initial errPulses = 0;
    always @(negedge clk) begin
        if (!rst && frame_err) errPulses++;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 5; i++) regModel[i] = 8'h00;
    endtask

    // Reference decode: only exact-length write frames to addresses 0..4 land.
    task automatic modelFrame(input logic [31:0] value, input int nbits);
        logic [6:0] a;
        a = value[14:8];
        if (nbits == 16 && value[15] && a <= 7'd4) begin
            regModel[a[2:0]] = value[7:0];
        end
`ifdef SPI_FRAME_ERR_EN
        else if (!(nbits == 16 && !value[15])) begin
            if (errModel < 255) errModel++;
        end
`endif
    endtask

    task automatic pushExpected();
        logic [39:0] s;
        for (int i = 0; i < 5; i++) s[8*i +: 8] = regModel[i];
        expQ.push_back(s);
    endtask

    task automatic popAndCompare(input string tag);
        logic [39:0] e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, "_reg0"}, 32'(en_reg_out_7_0),  32'(e[7:0]));
        checkOutput({tag, "_reg1"}, 32'(en_reg_out_15_8), 32'(e[15:8]));
        checkOutput({tag, "_reg2"}, 32'(en_reg_pwm_7_0),  32'(e[23:16]));
        checkOutput({tag, "_reg3"}, 32'(en_reg_pwm_15_8), 32'(e[31:24]));
        checkOutput({tag, "_reg4"}, 32'(pwm_duty_cycle),  32'(e[39:32]));
    endtask

    task automatic shiftBits(input logic [31:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi_sync = value[i];
            waitCycles(1);
            sclk_sync = 1'b1;
            waitCycles(2);
            sclk_sync = 1'b0;
            waitCycles(1);
        end
    endtask

    // Drives one framed transfer, then leaves nCS high long enough for commit to settle.
    task automatic applyStimulus(input logic [31:0] value, input int nbits);
        ncs_sync = 1'b0;
        waitCycles(2);
        shiftBits(value, nbits);
        ncs_sync = 1'b1;
        modelFrame(value, nbits);
        pushExpected();
        waitCycles(3);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
`ifdef SPI_FRAME_ERR_EN
        errModel   = 0;
`endif
        clearModel();
        sclk_sync = 1'b0;
        copi_sync = 1'b0;
        ncs_sync  = 1'b1;
        rst       = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        pushExpected();
        popAndCompare("reset");
        waitCycles(3);
        pushExpected();
        popAndCompare("idle_after_reset");

        applyStimulus(32'h80F0, 16);
        popAndCompare("wr_addr0");

        applyStimulus(32'h8480, 16);
        popAndCompare("wr_addr4");
        applyStimulus(32'h83AA, 16);
        popAndCompare("wr_addr3");

        applyStimulus(32'h0455, 16);
        popAndCompare("read_frame");
        applyStimulus(32'h8555, 16);
        popAndCompare("addr_out_of_range");
        applyStimulus(32'h4079, 15);
        popAndCompare("short_frame");
        applyStimulus(32'h180F5, 17);
        popAndCompare("long_frame");
`ifdef SPI_FRAME_ERR_EN
        checkOutput("err_count", 32'(err_count), 32'(errModel));
        checkOutput("frame_err_pulses", 32'(errPulses), 32'(errModel));
`endif

        // Reset mid-frame: the remaining 8 bits can only form a short frame.
        ncs_sync = 1'b0;
        waitCycles(2);
        shiftBits(32'h82, 8);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        clearModel();
`ifdef SPI_FRAME_ERR_EN
        errModel = 0;
        errPulses = 0;
`endif
        shiftBits(32'hFF, 8);
        ncs_sync = 1'b1;
        pushExpected();
        waitCycles(3);
        popAndCompare("mid_frame_reset");

        applyStimulus(32'h82FF, 16);
        popAndCompare("wr_addr2_after_reset");

        for (int i = 0; i < 20; i++) begin
            copi_sync = i[0];
            waitCycles(1);
            sclk_sync = 1'b1;
            waitCycles(1);
            sclk_sync = 1'b0;
        end
        waitCycles(3);
        pushExpected();
        popAndCompare("sclk_while_ncs_high");

        applyStimulus(32'h8133, 16);
        popAndCompare("wr_addr1_after_idle_sclk");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
